// File: rtl/clock_pkg.sv
// Shared types and default timing constants for the 24-hour clock controller.
package clock_pkg;

   typedef enum logic [1:0] {NORMAL, SET_SEC, SET_MIN, SET_HOUR} set_state_t;

   localparam int unsigned REP_START_DEF   = 4;
   localparam int unsigned TIMEOUT_SEC_DEF = 30;
   localparam int unsigned TW_DEF          = 5;

endpackage

// File: rtl/key_repeat.sv
// ADJUST auto-repeat: counts en_rep ticks while held, then fires on every tick.
// fire is combinational; the caller registers it into the per-field strobes.
module key_repeat #(
   parameter int unsigned REP_START = 4
) (
   input  logic clk,
   input  logic n_rst,
   input  logic clr,
   input  logic hold,
   input  logic en_rep,
   input  logic pulse,
   output logic fire
);

   localparam int unsigned RW = $clog2(REP_START + 1);

   logic [RW-1:0] rep_cnt_q, rep_cnt_d;
   logic          rep_full;

   assign rep_full = (rep_cnt_q == RW'(REP_START));

   always_comb begin
      rep_cnt_d = rep_cnt_q;
      if (clr || !hold) begin
         rep_cnt_d = '0;
      end else if (en_rep && !rep_full) begin
         rep_cnt_d = rep_cnt_q + RW'(1);
      end
   end

   // A pulse coinciding with a repeat tick still yields a single fire.
   assign fire = pulse | (hold & en_rep & rep_full & ~clr);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rep_cnt_q <= '0;
      end else begin
         rep_cnt_q <= rep_cnt_d;
      end
   end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: mode FSM, inactivity timeout, increment strobes and
// blink/run enables for the seconds/minutes/hours datapath.
module time_set_ctrl
   import clock_pkg::*;
#(
   parameter int unsigned REP_START   = REP_START_DEF,
   parameter int unsigned TIMEOUT_SEC = TIMEOUT_SEC_DEF,
   parameter int unsigned TW          = TW_DEF
) (
   input  logic clk,
   input  logic n_rst,
   input  logic en1hz,
   input  logic sig2hz,
   input  logic en_rep,
   input  logic MODE,
   input  logic SELECT,
   input  logic ADJUST,
   input  logic ADJUST_HOLD,
   output logic SECINC,
   output logic MININC,
   output logic HOURINC,
   output logic SECON,
   output logic MINON,
   output logic HOURON,
   output logic RUN,
   output logic SETTING
);

   set_state_t    state_q, state_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          fire, rep_clr, to_expire, inc_ok, state_chg;

   // Any button activity (including a held ADJUST) cancels a pending timeout.
   assign to_expire = en1hz && (to_cnt_q == TW'(TIMEOUT_SEC - 1)) && !ADJUST && !ADJUST_HOLD;
   assign state_chg = (state_d != state_q);
   assign rep_clr   = state_chg || (state_q == NORMAL);

   always_comb begin
      state_d = state_q;
      if (MODE) begin
         state_d = (state_q == NORMAL) ? SET_SEC : NORMAL;
      end else if (SELECT) begin
         unique case (state_q)
            NORMAL:   state_d = NORMAL;
            SET_SEC:  state_d = SET_MIN;
            SET_MIN:  state_d = SET_HOUR;
            SET_HOUR: state_d = SET_SEC;
         endcase
      end else if (state_q != NORMAL && to_expire) begin
         state_d = NORMAL;
      end
   end

   always_comb begin
      to_cnt_d = to_cnt_q;
      if (MODE || SELECT || ADJUST || ADJUST_HOLD || rep_clr) begin
         to_cnt_d = '0;
      end else if (en1hz) begin
         to_cnt_d = to_cnt_q + TW'(1);
      end
   end

   key_repeat #(
      .REP_START (REP_START)
   ) u_key_repeat (
      .clk    (clk),
      .n_rst  (n_rst),
      .clr    (rep_clr),
      .hold   (ADJUST_HOLD),
      .en_rep (en_rep),
      .pulse  (ADJUST),
      .fire   (fire)
   );

   // MODE/SELECT win over ADJUST; the adjust request is simply dropped.
   assign inc_ok = fire && !MODE && !SELECT && (state_q != NORMAL) && !state_chg;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= NORMAL;
         to_cnt_q <= '0;
         SECINC   <= 1'b0;
         MININC   <= 1'b0;
         HOURINC  <= 1'b0;
         SECON    <= 1'b1;
         MINON    <= 1'b1;
         HOURON   <= 1'b1;
         RUN      <= 1'b1;
         SETTING  <= 1'b0;
      end else begin
         state_q  <= state_d;
         to_cnt_q <= to_cnt_d;
         SECINC   <= inc_ok && (state_q == SET_SEC);
         MININC   <= inc_ok && (state_q == SET_MIN);
         HOURINC  <= inc_ok && (state_q == SET_HOUR);
         SECON    <= (state_d == SET_SEC)  ? sig2hz : 1'b1;
         MINON    <= (state_d == SET_MIN)  ? sig2hz : 1'b1;
         HOURON   <= (state_d == SET_HOUR) ? sig2hz : 1'b1;
         RUN      <= (state_d != SET_SEC);
         SETTING  <= (state_d != NORMAL);
      end
   end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomised and directed bench for time_set_ctrl against a behavioural model
// that tracks the mode as a plain integer (0 normal, 1 sec, 2 min, 3 hour).
module tb_time_set_ctrl;

   localparam int REP = 4;
   localparam int TO  = 30;
   localparam logic [7:0] IDLE_VEC = 8'b0001_1110;

   logic clk = 1'b0;
   logic n_rst, en1hz, sig2hz, en_rep, MODE, SELECT, ADJUST, ADJUST_HOLD;
   logic SECINC, MININC, HOURINC, SECON, MINON, HOURON, RUN, SETTING;
   logic [7:0] obs, exp_v;

   int n_cmp = 0;
   int n_fail = 0;
   int m_state, m_to, m_rep;

   always #5 clk = ~clk;

   time_set_ctrl dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .en1hz       (en1hz),
      .sig2hz      (sig2hz),
      .en_rep      (en_rep),
      .MODE        (MODE),
      .SELECT      (SELECT),
      .ADJUST      (ADJUST),
      .ADJUST_HOLD (ADJUST_HOLD),
      .SECINC      (SECINC),
      .MININC      (MININC),
      .HOURINC     (HOURINC),
      .SECON       (SECON),
      .MINON       (MINON),
      .HOURON      (HOURON),
      .RUN         (RUN),
      .SETTING     (SETTING)
   );

   assign obs = {SECINC, MININC, HOURINC, SECON, MINON, HOURON, RUN, SETTING};

   task automatic model_reset();
      m_state = 0;
      m_to    = 0;
      m_rep   = 0;
      exp_v   = IDLE_VEC;
   endtask

   // One clock of the behavioural model using the inputs sampled at the edge.
   task automatic model_step(input bit md, sl, ad, hd, e1, er, s2);
      int nxt, field;
      bit fire;
      nxt = m_state;
      if (md) nxt = (m_state == 0) ? 1 : 0;
      else if (sl && m_state != 0) nxt = (m_state == 3) ? 1 : m_state + 1;
      else if (m_state != 0 && e1 && m_to == TO - 1 && !ad && !hd) nxt = 0;
      fire  = ad || (hd && er && m_rep == REP);
      field = (m_state != 0 && !md && !sl && nxt == m_state && fire) ? m_state : 0;
      if (nxt != m_state || m_state == 0 || !hd) m_rep = 0;
      else if (er && m_rep < REP) m_rep = m_rep + 1;
      if (md || sl || ad || hd || nxt != m_state || m_state == 0) m_to = 0;
      else if (e1) m_to = m_to + 1;
      exp_v[7] = (field == 1);
      exp_v[6] = (field == 2);
      exp_v[5] = (field == 3);
      exp_v[4] = (nxt == 1) ? s2 : 1'b1;
      exp_v[3] = (nxt == 2) ? s2 : 1'b1;
      exp_v[2] = (nxt == 3) ? s2 : 1'b1;
      exp_v[1] = (nxt != 1);
      exp_v[0] = (nxt != 0);
      m_state = nxt;
   endtask

   task automatic cycle(input bit md, sl, ad, hd, e1, er, s2);
      MODE = md; SELECT = sl; ADJUST = ad; ADJUST_HOLD = hd;
      en1hz = e1; en_rep = er; sig2hz = s2;
      @(posedge clk);
      model_step(md, sl, ad, hd, e1, er, s2);
      #1;
      MODE = 0; SELECT = 0; ADJUST = 0; en1hz = 0; en_rep = 0;
   endtask

   task automatic test_reset();
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0, 0);
      n_cmp++;
      if (obs !== 8'b0001_0111) begin
         n_fail++; $display("FAIL reset_pre: got %b want %b", obs, 8'b0001_0111);
      end
      #3 n_rst = 1'b0;
      #1;
      n_cmp++;
      if (obs !== IDLE_VEC) begin
         n_fail++; $display("FAIL reset_async: got %b want %b", obs, IDLE_VEC);
      end
      @(negedge clk);
      n_rst = 1'b1;
      model_reset();
      cycle(0, 0, 0, 0, 0, 0, 1);
      n_cmp++;
      if (obs !== exp_v || obs !== IDLE_VEC) begin
         n_fail++; $display("FAIL reset_release: got %b want %b", obs, IDLE_VEC);
      end
   endtask

   task automatic test_sequence();
      bit [4:0] md_seq = 5'b10001;
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < 4; j++) begin
            bit s2 = 1'($urandom_range(0, 1));
            if (j == 0) cycle(md_seq[i], !md_seq[i], 0, 0, 0, 0, s2);
            else        cycle(0, 0, 0, 0, 0, 0, s2);
            n_cmp++;
            if (obs !== exp_v) begin
               n_fail++; $display("FAIL seq step %0d.%0d: got %b want %b", i, j, obs, exp_v);
            end
         end
      end
   endtask

   task automatic test_adjust();
      int cnt = 0;
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 1, 0, 0, 0, 1'($urandom_range(0, 1)));
         cnt += int'(MININC);
         n_cmp++;
         if (obs !== exp_v || MININC !== 1'b1) begin
            n_fail++; $display("FAIL adjust_inc %0d: got %b want %b", i, obs, exp_v);
         end
         cycle(0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
         cnt += int'(MININC);
      end
      n_cmp++;
      if (cnt != 3) begin
         n_fail++; $display("FAIL adjust_count: got %0d want 3", cnt);
      end
      cycle(1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_hold();
      int cnt = 0;
      int first = 0;
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 10; k++) begin
         cycle(0, 0, 0, 1, 0, 0, 1'($urandom_range(0, 1)));
         cnt += int'(HOURINC);
         cycle(0, 0, 0, 1, 0, 1, 1'($urandom_range(0, 1)));
         if (HOURINC && first == 0) first = k;
         cnt += int'(HOURINC);
         n_cmp++;
         if (obs !== exp_v) begin
            n_fail++; $display("FAIL hold tick %0d: got %b want %b", k, obs, exp_v);
         end
      end
      for (int k = 0; k < 3; k++) begin
         cycle(0, 0, 0, 0, 0, 1, 0);
         cnt += int'(HOURINC);
      end
      n_cmp++;
      if (first != 5) begin
         n_fail++; $display("FAIL hold_first: got tick %0d want 5", first);
      end
      n_cmp++;
      if (cnt != 6) begin
         n_fail++; $display("FAIL hold_count: got %0d want 6", cnt);
      end
      cycle(1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_timeout();
      cycle(1, 0, 0, 0, 0, 0, 0);
      for (int t = 1; t <= 30; t++) begin
         cycle(0, 0, 0, 0, 1, 0, 0);
         n_cmp++;
         if (obs !== exp_v || SETTING !== (t < 30)) begin
            n_fail++; $display("FAIL timeout tick %0d: got %b want %b", t, obs, exp_v);
         end
      end
      cycle(1, 0, 0, 0, 0, 0, 0);
      for (int t = 1; t <= 31; t++) begin
         cycle(0, (t == 29), 0, 0, 1, 0, 0);
      end
      n_cmp++;
      if (obs !== 8'b0001_0111 || obs !== exp_v) begin
         n_fail++; $display("FAIL timeout_cancel: got %b want %b", obs, 8'b0001_0111);
      end
      cycle(1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_priority();
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0, 0);
      cycle(1, 0, 1, 0, 0, 0, 0);
      n_cmp++;
      if (obs !== exp_v || obs !== IDLE_VEC) begin
         n_fail++; $display("FAIL prio_mode_adj: got %b want %b", obs, IDLE_VEC);
      end
      cycle(0, 0, 1, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0, 0);
      n_cmp++;
      if (obs !== IDLE_VEC) begin
         n_fail++; $display("FAIL prio_normal_ignore: got %b want %b", obs, IDLE_VEC);
      end
   endtask

   task automatic test_random();
      bit hd = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 15) == 0) hd = ~hd;
         cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 11) == 0),
               ($urandom_range(0, 5) == 0), hd, ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
         n_cmp++;
         if (obs !== exp_v) begin
            n_fail++; $display("FAIL random cyc %0d: got %b want %b", i, obs, exp_v);
         end
      end
   endtask

   initial begin
      n_rst = 1'b0;
      MODE = 0; SELECT = 0; ADJUST = 0; ADJUST_HOLD = 0;
      en1hz = 0; en_rep = 0; sig2hz = 0;
      model_reset();
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      test_reset();
      test_sequence();
      test_adjust();
      test_hold();
      test_timeout();
      test_priority();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
